// File: rtl/eth_xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// eth_xgmii_tx_framer
//
// Converts 64-bit AXI-stream frames into 64-bit XGMII words for eth_phy_10g.
// It adds the start/preamble/SFD word, places the terminate from tkeep on the
// last beat, enforces the minimum inter-frame gap, and substitutes error words
// while the upstream source underruns mid-frame. Payload, including any FCS,
// passes through unchanged.
//
// Ports:
//   tx_clk, tx_rst   clock and synchronous active-high reset
//   cfg_tx_enable    1 = new frames may start (a frame in flight always completes)
//   s_axis_*         64-bit AXI-stream payload input, lane0 = bits[7:0] sent first
//   xgmii_txd/txc    registered XGMII data/control to eth_phy_10g
//   tx_underrun      one-cycle pulse for each error word emitted
//   frame_count      frames terminated, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module eth_xgmii_tx_framer #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int MIN_IFG_BYTES = 12
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic                  cfg_tx_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  tx_underrun,
  output logic [15:0]           frame_count
);

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERROR = 8'hFE;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{C_IDLE}};
  localparam logic [DATA_WIDTH-1:0] ERROR_WORD = {CTRL_WIDTH{C_ERROR}};
  localparam logic [DATA_WIDTH-1:0] START_WORD = {C_SFD, {(CTRL_WIDTH-2){C_PRE}}, C_START};

  // Longest gap needed is when the terminate word carries no idle bytes.
  localparam int IFG_WORDS_MAX = (MIN_IFG_BYTES + 7) / 8;
  localparam int CNT_W         = $clog2(IFG_WORDS_MAX + 2);
  localparam int LANE_W        = $clog2(CTRL_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        ifg_cnt_q, ifg_cnt_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic [CTRL_WIDTH-1:0]   txc_q, txc_d;
  logic                    underrun_q, underrun_d;
  logic [15:0]             frame_count_q, frame_count_d;

  logic [LANE_W-1:0]       last_n;
  logic                    last_full;
  logic [CNT_W-1:0]        ifg_load;
  logic                    start_ok;

  assign s_axis_tready = (state_q == ST_DATA);
  assign xgmii_txd     = txd_q;
  assign xgmii_txc     = txc_q;
  assign tx_underrun   = underrun_q;
  assign frame_count   = frame_count_q;

  assign start_ok = cfg_tx_enable && s_axis_tvalid;

  // Valid byte count on the last beat: index of the first zero in tkeep, so a
  // non-contiguous mask is cut at its first hole.
  always_comb begin
    logic found;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    last_n = LANE_W'(CTRL_WIDTH);
    found  = 1'b0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (!found && !s_axis_tkeep[i]) begin
        last_n = LANE_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign last_full = (last_n == LANE_W'(CTRL_WIDTH));

  // Idle words still owed after the terminate word so that, counting the idle
  // lanes already inside it, at least MIN_IFG_BYTES idle bytes precede the next
  // start. At least one full idle word is always sent so a start never sits
  // directly after a terminate.
  always_comb begin
    int idle_bytes;
    int ifg_words;
    if (state_q == ST_TERM) idle_bytes = CTRL_WIDTH - 1;
    else                    idle_bytes = CTRL_WIDTH - 1 - int'(last_n);
    ifg_words = (MIN_IFG_BYTES - idle_bytes + 7) / 8;
    if (ifg_words < 1) ifg_words = 1;
    ifg_load = CNT_W'(ifg_words);
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ifg_cnt_d = ifg_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          if (last_full) begin
            state_d = ST_TERM;
          end else begin
            state_d   = ST_IFG;
            ifg_cnt_d = ifg_load;
          end
        end
      end
      ST_TERM: begin
        state_d   = ST_IFG;
        ifg_cnt_d = ifg_load;
      end
      ST_IFG: begin
        ifg_cnt_d = ifg_cnt_q - CNT_W'(1);
        if (ifg_cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the XGMII word to register at the next edge.
  always_comb begin
    txd_d         = IDLE_WORD;
    txc_d         = '1;
    underrun_d    = 1'b0;
    frame_count_d = frame_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          txd_d = START_WORD;
          txc_d = CTRL_WIDTH'(1);
        end
      end
      ST_DATA: begin
        if (!s_axis_tvalid) begin
          // Source ran dry mid-frame: poison the frame instead of stretching it.
          txd_d      = ERROR_WORD;
          underrun_d = 1'b1;
        end else if (!s_axis_tlast || last_full) begin
          txd_d = s_axis_tdata;
          txc_d = '0;
        end else begin
          // Partial last beat: data lanes, terminate right after, idles above.
          for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (LANE_W'(i) < last_n) begin
              txd_d[8*i +: 8] = s_axis_tdata[8*i +: 8];
              txc_d[i]        = 1'b0;
            end else if (LANE_W'(i) == last_n) begin
              txd_d[8*i +: 8] = C_TERM;
            end
          end
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      ST_TERM: begin
        txd_d[7:0]    = C_TERM;
        frame_count_d = frame_count_q + 16'd1;
      end
      default: ;
    endcase
  end

  // State register. A reset mid-frame drops straight to idle without a
  // terminate; the PHY sees the truncated frame as a framing error.
  always_ff @(posedge tx_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (tx_rst) begin
      state_q       <= ST_IDLE;
      ifg_cnt_q     <= '0;
      txd_q         <= IDLE_WORD;
      txc_q         <= '1;
      underrun_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ifg_cnt_q     <= ifg_cnt_d;
      txd_q         <= txd_d;
      txc_q         <= txc_d;
      underrun_q    <= underrun_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
